jtframe_dwnld_ctrl: RTL and testbench



---
 rtl/jtframe_dwnld_pkg.sv | 15 +
 rtl/jtframe_dwnld_ctrl_if.sv | 24 ++
 rtl/jtframe_dwnld_fifo.sv | 37 +++
 rtl/jtframe_dwnld_ctrl.sv | 93 +++++++++
 tb/tb_jtframe_dwnld_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/jtframe_dwnld_pkg.sv
// jtframe_dwnld_pkg: write FSM states, default SDRAM bank map and FIFO entry layout
package jtframe_dwnld_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, POST} state_e;
  localparam logic [24:0] BA1_DEF = 25'h10_0000;
  localparam logic [24:0] BA2_DEF = 25'h20_0000;
  localparam logic [24:0] BA3_DEF = 25'h30_0000;
  localparam logic [24:0] END_DEF = 25'h40_0000;
  typedef struct packed {
    logic [21:0] addr;
    logic [1:0]  bank;
    logic [1:0]  mask;
    logic [7:0]  data;
  } entry_t;
  localparam entry_t ENTRY_RST = {22'd0, 2'd0, 2'b11, 8'd0};
endpackage

// File: rtl/jtframe_dwnld_ctrl_if.sv
// jtframe_dwnld_ctrl_if: ioctl download stream in, SDRAM programming port out
// master: the download controller; slave: the MiST base / SDRAM controller side
interface jtframe_dwnld_ctrl_if;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_bank;
  logic        prog_we;
  logic        prog_ack;
  logic        dwnld_busy;
  logic        overflow;
  modport master (
    input  downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_ack,
    output prog_addr, prog_data, prog_mask, prog_bank, prog_we, dwnld_busy, overflow
  );
  modport slave (
    output downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_ack,
    input  prog_addr, prog_data, prog_mask, prog_bank, prog_we, dwnld_busy, overflow
  );
endinterface

// File: rtl/jtframe_dwnld_fifo.sv
// jtframe_dwnld_fifo: 2-entry buffer of pending SDRAM byte writes
// ports: clk_rom/rst_n, push_i/din_i write side, pop_i/head_o read side, full_o/empty_o status
module jtframe_dwnld_fifo
  import jtframe_dwnld_pkg::*;
(
  input  logic   clk_rom,
  input  logic   rst_n,
  input  logic   push_i,
  input  logic   pop_i,
  input  entry_t din_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);
  entry_t     mem_q [2];
  logic       wp_q, rp_q, wr, rd;
  logic [1:0] cnt_q;
  assign full_o  = cnt_q == 2'd2;
  assign empty_o = cnt_q == 2'd0;
  assign head_o  = mem_q[rp_q];
  assign rd      = pop_i && !empty_o;
  // a pop frees the slot in the same cycle, so a full FIFO still accepts a push
  assign wr      = push_i && (!full_o || rd);
  always_ff @(posedge clk_rom or negedge rst_n)
    if (!rst_n) begin
      mem_q[0] <= ENTRY_RST;
      mem_q[1] <= ENTRY_RST;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (wr) mem_q[wp_q] <= din_i;
      wp_q  <= wp_q ^ wr;
      rp_q  <= rp_q ^ rd;
      cnt_q <= cnt_q + {1'b0, wr} - {1'b0, rd};
    end
endmodule

// File: rtl/jtframe_dwnld_ctrl.sv
// jtframe_dwnld_ctrl: maps the ioctl ROM byte stream onto SDRAM bank/word writes
// ports: clk_rom, rst_n (async, active low), bus (master side of jtframe_dwnld_ctrl_if)
module jtframe_dwnld_ctrl
  import jtframe_dwnld_pkg::*;
#(
  parameter logic [24:0] HEADER      = 25'd0,
  parameter logic [24:0] BA1_START   = BA1_DEF,
  parameter logic [24:0] BA2_START   = BA2_DEF,
  parameter logic [24:0] BA3_START   = BA3_DEF,
  parameter logic [24:0] ROM_END     = END_DEF,
  parameter logic        SWAB        = 1'b0,
  parameter int          POST_CYCLES = 16
)(
  input logic                  clk_rom,
  input logic                  rst_n,
  jtframe_dwnld_ctrl_if.master bus
);
  localparam int CW = $clog2(POST_CYCLES + 2);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, ovf_q, wr_q, borrow, push, pop, full, empty;
  logic [24:0]   addr_q, off, start;
  logic [22:0]   boff;
  logic [7:0]    data_q;
  logic [1:0]    bank;
  entry_t        din, head;
  always_ff @(posedge clk_rom or negedge rst_n)
    if (!rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= bus.ioctl_wr && bus.downloading;
      addr_q  <= bus.ioctl_addr;
      data_q  <= bus.ioctl_data;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_q | (push && full && !pop);
    end
  // the subtraction borrow flags bytes still inside the header
  always_comb begin
    {borrow, off} = {1'b0, addr_q} - {1'b0, HEADER};
    bank  = off < BA1_START ? 2'd0 : off < BA2_START ? 2'd1 : off < BA3_START ? 2'd2 : 2'd3;
    start = bank == 2'd0 ? 25'd0 : bank == 2'd1 ? BA1_START : bank == 2'd2 ? BA2_START : BA3_START;
    boff  = 23'(off - start);
    push  = wr_q && !borrow && off < ROM_END;
    din   = {boff[22:1], bank, (boff[0] ^ SWAB) ? 2'b01 : 2'b10, data_q};
  end
  // WRITE always falls back to IDLE after an ack, giving one prog_we-low cycle between writes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q | bus.downloading;
    pop     = 1'b0;
    if (state_q == IDLE) begin
      if (!empty) state_d = WRITE;
      else if (busy_q && !bus.downloading && !wr_q) begin
        state_d = POST;
        cnt_d   = CW'(POST_CYCLES);
      end
    end else if (state_q == WRITE) begin
      pop     = bus.prog_ack;
      state_d = bus.prog_ack ? IDLE : WRITE;
    end else if (bus.downloading) state_d = IDLE;
    else if (cnt_q <= CW'(1)) begin
      state_d = IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else cnt_d = cnt_q - 1'b1;
  end
  jtframe_dwnld_fifo u_fifo (
    .clk_rom (clk_rom),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  assign bus.prog_addr  = head.addr;
  assign bus.prog_data  = head.data;
  assign bus.prog_mask  = head.mask;
  assign bus.prog_bank  = head.bank;
  assign bus.prog_we    = state_q == WRITE;
  assign bus.dwnld_busy = busy_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_jtframe_dwnld_ctrl.sv
// tb_jtframe_dwnld_ctrl: directed checks on three variants (default, HEADER=4, SWAB=1)
module tb_jtframe_dwnld_ctrl;
  import jtframe_dwnld_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, downloading = 1'b0, ioctl_wr = 1'b0, ack_en = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic [7:0]  dat [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  int          vecs = 0, errs = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    jtframe_dwnld_ctrl_if bus();
    logic   ack = 1'b0;
    int     w = 0;
    entry_t q[$];
    assign bus.downloading = downloading;
    assign bus.ioctl_addr  = ioctl_addr;
    assign bus.ioctl_data  = ioctl_data;
    assign bus.ioctl_wr    = ioctl_wr;
    assign bus.prog_ack    = ack;
    jtframe_dwnld_ctrl #(.HEADER(25'(g == 1 ? 4 : 0)), .SWAB(g == 2)) dut (
      .clk_rom (clk),
      .rst_n   (rst_n),
      .bus     (bus.master)
    );
    always @(negedge clk)
      if (!rst_n || !bus.prog_we || ack) begin
        ack = 1'b0;
        w   = 0;
      end else if (ack_en) begin
        w = w + 1;
        if (w == 2) ack = 1'b1;
      end
    always @(posedge clk)
      if (bus.prog_we && ack) q.push_back({bus.prog_addr, bus.prog_bank, bus.prog_mask, bus.prog_data});
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic strobe(input logic [24:0] a, input logic [7:0] d, input int gap);
    @(negedge clk);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (gap) @(negedge clk);
  endtask
  task automatic rst_outputs(input string t);
    check({t, "_addr"}, 32'(u[0].bus.prog_addr), 0);
    check({t, "_data"}, 32'(u[0].bus.prog_data), 0);
    check({t, "_mask"}, 32'(u[0].bus.prog_mask), 3);
    check({t, "_bank"}, 32'(u[0].bus.prog_bank), 0);
    check({t, "_we"}, 32'(u[0].bus.prog_we), 0);
    check({t, "_busy"}, 32'(u[0].bus.dwnld_busy), 0);
    check({t, "_ovf"}, 32'(u[0].bus.overflow), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end
  initial begin
    entry_t e;
    int     b0, b1, b2, n;
    logic   seen;
    repeat (3) @(negedge clk);
    rst_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    downloading = 1'b1;
    check("busy_pre", 32'(u[0].bus.dwnld_busy), 0);
    @(negedge clk);
    check("busy_rise", 32'(u[0].bus.dwnld_busy), 1);
    ack_en = 1'b1;
    b0 = u[0].q.size();
    b1 = u[1].q.size();
    for (int i = 0; i < 4; i++) strobe(25'(i), dat[i], 8);
    check("seq_n", u[0].q.size() - b0, 4);
    for (int i = 0; i < 4; i++) begin
      e = u[0].q[b0 + i];
      check($sformatf("seq%0d_addr", i), 32'(e.addr), i / 2);
      check($sformatf("seq%0d_mask", i), 32'(e.mask), (i % 2) ? 1 : 2);
      check($sformatf("seq%0d_bank", i), 32'(e.bank), 0);
      check($sformatf("seq%0d_data", i), 32'(e.data), 32'(dat[i]));
    end
    check("hdr_skip", u[1].q.size() - b1, 0);
    b1 = u[1].q.size();
    strobe(25'd4, 8'h55, 8);
    check("hdr_n", u[1].q.size() - b1, 1);
    e = u[1].q[b1];
    check("hdr_addr", 32'(e.addr), 0);
    check("hdr_mask", 32'(e.mask), 2);
    check("hdr_data", 32'(e.data), 32'h55);
    b0 = u[0].q.size();
    b2 = u[2].q.size();
    strobe(25'h10_0003, 8'h66, 8);
    e = u[0].q[b0];
    check("ba1_bank", 32'(e.bank), 1);
    check("ba1_addr", 32'(e.addr), 1);
    check("ba1_mask", 32'(e.mask), 1);
    e = u[2].q[b2];
    check("swab_bank", 32'(e.bank), 1);
    check("swab_mask", 32'(e.mask), 2);
    ack_en = 1'b0;
    b0 = u[0].q.size();
    strobe(25'd8, 8'h11, 3);
    strobe(25'd9, 8'h22, 3);
    strobe(25'd10, 8'h33, 4);
    check("ovf_we", 32'(u[0].bus.prog_we), 1);
    check("ovf_flag", 32'(u[0].bus.overflow), 1);
    check("ovf_held", u[0].q.size() - b0, 0);
    ack_en = 1'b1;
    repeat (20) @(negedge clk);
    check("ovf_n", u[0].q.size() - b0, 2);
    e = u[0].q[b0];
    check("ovf0_data", 32'(e.data), 32'h11);
    check("ovf0_addr", 32'(e.addr), 4);
    check("ovf0_mask", 32'(e.mask), 2);
    e = u[0].q[b0 + 1];
    check("ovf1_data", 32'(e.data), 32'h22);
    check("ovf1_mask", 32'(e.mask), 1);
    downloading = 1'b0;
    n = 0;
    while (u[0].bus.dwnld_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("post_len", n, 17);
    check("ovf_sticky", 32'(u[0].bus.overflow), 1);
    b0 = u[0].q.size();
    strobe(25'h30, 8'h99, 6);
    check("idle_wr_n", u[0].q.size() - b0, 0);
    check("idle_busy", 32'(u[0].bus.dwnld_busy), 0);
    downloading = 1'b1;
    repeat (2) @(negedge clk);
    check("busy_back", 32'(u[0].bus.dwnld_busy), 1);
    downloading = 1'b0;
    repeat (12) @(negedge clk);
    downloading = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen |= !u[0].bus.dwnld_busy;
    end
    check("post_abort", 32'(seen), 0);
    ack_en = 1'b0;
    b0 = u[0].q.size();
    strobe(25'h20, 8'h77, 3);
    strobe(25'h21, 8'h88, 4);
    check("rw_we", 32'(u[0].bus.prog_we), 1);
    #2 rst_n = 1'b0;
    #1 rst_outputs("rst_mid");
    @(negedge clk);
    ack_en = 1'b1;
    rst_n  = 1'b1;
    seen   = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= u[0].bus.prog_we;
    end
    check("rst_no_we", 32'(seen), 0);
    check("rst_no_wr", u[0].q.size() - b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
